// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage.
// Extracts zero/sign-extended immediates from the instruction word. A PREFIX
// select latches upper bits that are merged into the next real immediate.
// One cycle of latency, with stall (hold everything) and flush (drop prefix
// and in-flight result) controls from the hazard logic.
module imm_gen_pipe #(
    parameter int INSTR_W  = 8,
    parameter int DATA_W   = 8,
    parameter int SHAMT_W  = 3,
    parameter int JCONST_W = 6,
    parameter int PREFIX_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         imm_sel,
    output logic               out_valid,
    output logic [DATA_W-1:0]  imm,
    output logic               prefix_pending
);

    // Wide enough to hold any field extended to DATA_W, so narrow fields get
    // padded and wide fields are simply cut back to their low DATA_W bits.
    localparam int EXT_W = DATA_W + SHAMT_W + JCONST_W;

    typedef enum logic [1:0] {
        SEL_ZEXT_SHAMT  = 2'b00,
        SEL_ZEXT_JCONST = 2'b01,
        SEL_SEXT_JCONST = 2'b10,
        SEL_PREFIX      = 2'b11
    } imm_sel_e;

    // IDLE: no prefix captured. HELD: a prefix waits to be merged.
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                out_valid_q, out_valid_d;

    logic [SHAMT_W-1:0]  shamt_field;
    logic [JCONST_W-1:0] jconst_field;
    logic [EXT_W-1:0]    shamt_zext;
    logic [EXT_W-1:0]    jconst_zext;
    logic [EXT_W-1:0]    jconst_sext;
    logic [DATA_W-1:0]   base;
    logic [DATA_W-1:0]   merged;
    imm_sel_e            sel;
    logic                unused_bits;

    assign sel          = imm_sel_e'(imm_sel);
    assign shamt_field  = instr[SHAMT_W-1:0];
    assign jconst_field = instr[JCONST_W-1:0];
    assign shamt_zext   = EXT_W'(shamt_field);
    assign jconst_zext  = EXT_W'(jconst_field);
    assign jconst_sext  = EXT_W'(signed'(jconst_field));

    // Upper instruction bits and the extension headroom are intentionally unused.
    assign unused_bits  = ^{instr, shamt_zext, jconst_zext, jconst_sext};

    // Select the base immediate for the current instruction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        base = shamt_zext[DATA_W-1:0];
        unique case (sel)
            SEL_ZEXT_SHAMT:  base = shamt_zext[DATA_W-1:0];
            SEL_ZEXT_JCONST: base = jconst_zext[DATA_W-1:0];
            SEL_SEXT_JCONST: base = jconst_sext[DATA_W-1:0];
            SEL_PREFIX:      base = '0;
        endcase
    end

    // A pending prefix replaces the top PREFIX_W bits of the base value.
    assign merged = (state_q == HELD) ? {prefix_q, base[DATA_W-PREFIX_W-1:0]} : base;

    // Next-state logic: flush beats stall beats normal operation.
    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        imm_d       = imm_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = IDLE;
            prefix_d    = '0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
                if (sel == SEL_PREFIX) begin
                    state_d  = HELD;
                    prefix_d = instr[PREFIX_W-1:0];
                end else begin
                    state_d     = IDLE;
                    imm_d       = merged;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            prefix_q    <= '0;
            imm_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            imm_q       <= imm_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign imm            = imm_q;
    assign prefix_pending = (state_q == HELD);

endmodule
